// File: rtl/fifo_burst_reader.sv
// Reads one fixed-length burst from an async FIFO read port and forwards it
// downstream through a 2-entry skid buffer with valid/ready handshaking.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 256,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = $clog2(BURST_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  fifo_valid,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] LP_LEN  = CNT_WIDTH'(BURST_LEN);
  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(BURST_LEN - 1);

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_issued;
  logic [CNT_WIDTH-1:0]  r_sent;
  logic                  r_inflight;
  logic                  r_clr_d;
  logic                  r_err;
  logic                  r_hd;
  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_buf [2];

  logic w_room;
  logic w_rd;
  logic w_push;
  logic w_pop;
  logic w_spur;
  logic w_tail;

  // A read is only issued when the buffer can absorb it plus any word still in flight.
  assign w_room = (r_occ == 2'd0) || ((r_occ == 2'd1) && !r_inflight);
  assign w_rd   = (r_state == S_READ) && !clr && !fifo_empty && (r_issued < LP_LEN) && w_room;
  assign w_push = fifo_valid && r_inflight;
  assign w_spur = fifo_valid && !r_inflight && !r_clr_d;
  assign w_pop  = m_valid && m_ready;
  assign w_tail = r_hd ^ r_occ[0];

  assign fifo_rd_en = w_rd;
  assign m_valid    = (r_occ != 2'd0);
  assign m_data     = r_buf[r_hd];
  assign m_last     = m_valid && (r_sent == LP_LAST);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign err        = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_issued   <= '0;
      r_sent     <= '0;
      r_inflight <= 1'b0;
      r_clr_d    <= 1'b0;
      r_err      <= 1'b0;
      r_hd       <= 1'b0;
      r_occ      <= 2'd0;
      for (int i = 0; i < 2; i++) r_buf[i] <= '0;
    end else if (clr) begin
      r_state    <= S_IDLE;
      r_issued   <= '0;
      r_sent     <= '0;
      r_inflight <= 1'b0;
      r_clr_d    <= 1'b1;
      r_err      <= 1'b0;
      r_hd       <= 1'b0;
      r_occ      <= 2'd0;
    end else begin
      r_clr_d    <= 1'b0;
      r_inflight <= w_rd;
      if (w_spur) r_err <= 1'b1;
      if (w_push) r_buf[w_tail] <= fifo_dout;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
      if (w_pop) begin
        r_hd   <= ~r_hd;
        r_sent <= r_sent + 1'b1;
      end
      if (w_rd) r_issued <= r_issued + 1'b1;

      // Counter clears in IDLE override the increments above.
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_READ;
            r_issued <= '0;
            r_sent   <= '0;
          end
        end
        S_READ: begin
          if (w_rd && (r_issued == LP_LAST)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_pop && (r_sent == LP_LAST)) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
